pipe_hazard_ctrl: RTL and testbench



---
 rtl/pipe_hazard_ctrl_pkg.sv | 21 ++
 rtl/pipe_hazard_ctrl_sat_counter.sv | 30 +++
 rtl/pipe_hazard_ctrl.sv | 172 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// ============================================================================
// pipe_pkg : shared state encoding and ISA constants for pipe_hazard_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

package pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MDU_WAIT = 2'd1,
    ST_REDIRECT = 2'd2
  } state_e;

  // addi x0, x0, 0
  localparam logic [31:0] c_nop_instr = 32'h0000_0013;
  localparam logic [4:0]  c_x0        = 5'd0;

endpackage

`default_nettype wire

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// ============================================================================
// sat_counter : synchronous-clear up counter that sticks at all-ones
// Rev 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign cnt_o = r_cnt;

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// pipe_hazard_ctrl : stall/flush sequencer for the 5-stage RV32E pipeline
// Rev 1.0
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int FLUSH_DEPTH = 1,
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             start_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  logic [4:0]       idex_rd_i,
  input  logic             idex_mem_read_i,
  input  logic             idex_mdu_i,
  input  logic             branch_taken_i,
  input  logic             dmem_busy_i,
  input  logic             mdu_done_i,
  output logic             pc_write_o,
  output logic             if_id_hazard_o,
  output logic             if_id_flush_o,
  output logic             id_ex_hold_o,
  output logic             id_ex_bubble_o,
  output logic             ex_mem_hold_o,
  output logic             ex_mem_bubble_o,
  output logic             mdu_start_o,
  output logic             mdu_timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int WD_W = $clog2(MDU_TIMEOUT + 1);

  state_e          r_state, w_state_nxt;
  logic [1:0]      r_remain, w_remain_nxt;
  logic [WD_W-1:0] r_wdog, w_wdog_nxt;
  logic            r_done_seen, w_done_seen_nxt;
  logic            r_timeout, w_timeout_nxt;
  logic            w_load_use;
  logic            w_flush_evt;

  assign w_load_use = idex_mem_read_i && (idex_rd_i != c_x0) &&
                      ((id_rs1_used_i && (id_rs1_i == idex_rd_i)) ||
                       (id_rs2_used_i && (id_rs2_i == idex_rd_i)));

  always_comb begin
    pc_write_o      = 1'b1;
    if_id_hazard_o  = 1'b0;
    if_id_flush_o   = 1'b0;
    id_ex_hold_o    = 1'b0;
    id_ex_bubble_o  = 1'b0;
    ex_mem_hold_o   = 1'b0;
    ex_mem_bubble_o = 1'b0;
    mdu_start_o     = 1'b0;
    w_flush_evt     = 1'b0;
    w_state_nxt     = r_state;
    w_remain_nxt    = r_remain;
    w_wdog_nxt      = r_wdog;
    w_done_seen_nxt = r_done_seen;
    w_timeout_nxt   = r_timeout;

    if (!start_i) begin
      pc_write_o     = 1'b0;
      id_ex_bubble_o = 1'b1;
    end else if (dmem_busy_i) begin
      // Whole pipe frozen; a completion arriving now is remembered for later.
      pc_write_o     = 1'b0;
      if_id_hazard_o = 1'b1;
      id_ex_hold_o   = 1'b1;
      ex_mem_hold_o  = 1'b1;
      if ((r_state == ST_MDU_WAIT) && mdu_done_i) begin
        w_done_seen_nxt = 1'b1;
      end
    end else begin
      case (r_state)
        ST_RUN: begin
          if (idex_mdu_i) begin
            mdu_start_o     = 1'b1;
            pc_write_o      = 1'b0;
            if_id_hazard_o  = 1'b1;
            id_ex_hold_o    = 1'b1;
            ex_mem_bubble_o = 1'b1;
            w_state_nxt     = ST_MDU_WAIT;
            w_wdog_nxt      = '0;
            w_done_seen_nxt = 1'b0;
          end else if (branch_taken_i) begin
            if_id_flush_o  = 1'b1;
            id_ex_bubble_o = 1'b1;
            w_flush_evt    = 1'b1;
            if (FLUSH_DEPTH > 1) begin
              w_state_nxt  = ST_REDIRECT;
              w_remain_nxt = 2'(FLUSH_DEPTH - 1);
            end
          end else if (w_load_use) begin
            pc_write_o     = 1'b0;
            if_id_hazard_o = 1'b1;
            id_ex_bubble_o = 1'b1;
          end
        end
        ST_MDU_WAIT: begin
          if (mdu_done_i || r_done_seen) begin
            w_state_nxt     = ST_RUN;
            w_done_seen_nxt = 1'b0;
          end else if (r_wdog == WD_W'(MDU_TIMEOUT)) begin
            w_timeout_nxt   = 1'b1;
            w_state_nxt     = ST_RUN;
            w_done_seen_nxt = 1'b0;
          end else begin
            pc_write_o      = 1'b0;
            if_id_hazard_o  = 1'b1;
            id_ex_hold_o    = 1'b1;
            ex_mem_bubble_o = 1'b1;
            w_wdog_nxt      = r_wdog + WD_W'(1);
          end
        end
        ST_REDIRECT: begin
          if_id_flush_o  = 1'b1;
          id_ex_bubble_o = 1'b1;
          w_remain_nxt   = r_remain - 2'd1;
          if (r_remain <= 2'd1) begin
            w_state_nxt = ST_RUN;
          end
        end
        default: begin
          w_state_nxt = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!start_i) begin
      r_state     <= ST_RUN;
      r_remain    <= 2'd0;
      r_wdog      <= '0;
      r_done_seen <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_remain    <= w_remain_nxt;
      r_wdog      <= w_wdog_nxt;
      r_done_seen <= w_done_seen_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  assign mdu_timeout_o = r_timeout;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .clr_i (~start_i),
    .inc_i (start_i & ~pc_write_o),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .clr_i (~start_i),
    .inc_i (w_flush_evt),
    .cnt_o (flush_cnt_o)
  );

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// tb_pipe_hazard_ctrl : directed self-checking bench for pipe_hazard_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 16;

  // {pc_write, if_id_hazard, if_id_flush, id_ex_hold, id_ex_bubble, ex_mem_hold, ex_mem_bubble, mdu_start}
  localparam logic [7:0] c_run    = 8'b1000_0000;
  localparam logic [7:0] c_reset  = 8'b0000_1000;
  localparam logic [7:0] c_freeze = 8'b0101_0100;
  localparam logic [7:0] c_launch = 8'b0101_0011;
  localparam logic [7:0] c_wait   = 8'b0101_0010;
  localparam logic [7:0] c_flush  = 8'b1010_1000;
  localparam logic [7:0] c_ldstl  = 8'b0100_1000;

  logic clk_i = 1'b0;
  logic start_i;
  logic [4:0] id_rs1_i, id_rs2_i, idex_rd_i;
  logic id_rs1_used_i, id_rs2_used_i, idex_mem_read_i, idex_mdu_i;
  logic branch_taken_i, dmem_busy_i, mdu_done_i;
  logic pc_write_o, if_id_hazard_o, if_id_flush_o, id_ex_hold_o, id_ex_bubble_o;
  logic ex_mem_hold_o, ex_mem_bubble_o, mdu_start_o, mdu_timeout_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;
  logic [7:0] w_ctl;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  assign w_ctl = {pc_write_o, if_id_hazard_o, if_id_flush_o, id_ex_hold_o,
                  id_ex_bubble_o, ex_mem_hold_o, ex_mem_bubble_o, mdu_start_o};

  pipe_hazard_ctrl #(
    .FLUSH_DEPTH (2),
    .MDU_TIMEOUT (8),
    .CNT_W       (CNT_W)
  ) u_dut (
    .clk_i           (clk_i),
    .start_i         (start_i),
    .id_rs1_i        (id_rs1_i),
    .id_rs2_i        (id_rs2_i),
    .id_rs1_used_i   (id_rs1_used_i),
    .id_rs2_used_i   (id_rs2_used_i),
    .idex_rd_i       (idex_rd_i),
    .idex_mem_read_i (idex_mem_read_i),
    .idex_mdu_i      (idex_mdu_i),
    .branch_taken_i  (branch_taken_i),
    .dmem_busy_i     (dmem_busy_i),
    .mdu_done_i      (mdu_done_i),
    .pc_write_o      (pc_write_o),
    .if_id_hazard_o  (if_id_hazard_o),
    .if_id_flush_o   (if_id_flush_o),
    .id_ex_hold_o    (id_ex_hold_o),
    .id_ex_bubble_o  (id_ex_bubble_o),
    .ex_mem_hold_o   (ex_mem_hold_o),
    .ex_mem_bubble_o (ex_mem_bubble_o),
    .mdu_start_o     (mdu_start_o),
    .mdu_timeout_o   (mdu_timeout_o),
    .stall_cnt_o     (stall_cnt_o),
    .flush_cnt_o     (flush_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and land 1 ns after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    id_rs1_i = 5'd0; id_rs2_i = 5'd0; idex_rd_i = 5'd0;
    id_rs1_used_i = 1'b0; id_rs2_used_i = 1'b0;
    idex_mem_read_i = 1'b0; idex_mdu_i = 1'b0; branch_taken_i = 1'b0;
    dmem_busy_i = 1'b0; mdu_done_i = 1'b0;
  endtask

  task automatic do_reset();
    start_i = 1'b0;
    #1 chk("rst_ctl", 32'(w_ctl), 32'(c_reset));
    tick();
    start_i = 1'b1;
  endtask

  initial begin
    idle();
    start_i = 1'b0;
    #2 chk("por_ctl", 32'(w_ctl), 32'(c_reset));
    tick();
    chk("por_stall", 32'(stall_cnt_o), 0);
    chk("por_flush", 32'(flush_cnt_o), 0);
    chk("por_tmo", 32'(mdu_timeout_o), 0);
    start_i = 1'b1;
    #1 chk("run_idle", 32'(w_ctl), 32'(c_run));
    tick();

    // Load-use: lw x5 in EX, ID reads x5 through rs2
    idex_rd_i = 5'd5; idex_mem_read_i = 1'b1;
    id_rs1_i = 5'd3; id_rs1_used_i = 1'b1;
    id_rs2_i = 5'd5; id_rs2_used_i = 1'b1;
    #1 chk("ldu_stall", 32'(w_ctl), 32'(c_ldstl));
    tick();
    idex_mem_read_i = 1'b0;
    #1 chk("ldu_release", 32'(w_ctl), 32'(c_run));
    chk("ldu_cnt", 32'(stall_cnt_o), 1);
    tick();
    // rd = x0 never stalls
    idex_mem_read_i = 1'b1; idex_rd_i = 5'd0; id_rs1_i = 5'd0; id_rs2_i = 5'd0;
    #1 chk("ldu_x0", 32'(w_ctl), 32'(c_run));
    // matching register that is not actually read
    idex_rd_i = 5'd9; id_rs2_i = 5'd9; id_rs2_used_i = 1'b0;
    #1 chk("ldu_unused", 32'(w_ctl), 32'(c_run));
    // rs1 match
    id_rs1_i = 5'd9;
    #1 chk("ldu_rs1", 32'(w_ctl), 32'(c_ldstl));
    idex_mem_read_i = 1'b0;
    #1 chk("ldu_noload", 32'(w_ctl), 32'(c_run));
    tick();
    chk("ldu_cnt2", 32'(stall_cnt_o), 1);
    idle();

    // Branch with FLUSH_DEPTH=2; second branch and MDU inside REDIRECT are ignored
    branch_taken_i = 1'b1;
    #1 chk("br_flush0", 32'(w_ctl), 32'(c_flush));
    tick();
    chk("br_cnt", 32'(flush_cnt_o), 1);
    idex_mdu_i = 1'b1;
    #1 chk("br_flush1", 32'(w_ctl), 32'(c_flush));
    tick();
    chk("br_cnt_ign", 32'(flush_cnt_o), 1);
    idle();
    #1 chk("br_done", 32'(w_ctl), 32'(c_run));
    chk("br_nostall", 32'(stall_cnt_o), 1);
    tick();

    // MDU: launch + 5 wait cycles, done on the 6th
    do_reset();
    chk("mdu_cnt0", 32'(stall_cnt_o), 0);
    idex_mdu_i = 1'b1;
    #1 chk("mdu_launch", 32'(w_ctl), 32'(c_launch));
    tick();
    idex_mdu_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 chk("mdu_wait", 32'(w_ctl), 32'(c_wait));
      tick();
    end
    mdu_done_i = 1'b1;
    #1 chk("mdu_rel", 32'(w_ctl), 32'(c_run));
    tick();
    mdu_done_i = 1'b0;
    chk("mdu_stall", 32'(stall_cnt_o), 6);
    #1 chk("mdu_run", 32'(w_ctl), 32'(c_run));
    tick();

    // Watchdog: 8 held wait cycles, then the timeout cycle releases
    idex_mdu_i = 1'b1;
    tick();
    idex_mdu_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1 chk("wd_wait", 32'(w_ctl), 32'(c_wait));
      tick();
    end
    #1 chk("wd_rel", 32'(w_ctl), 32'(c_run));
    chk("wd_pre", 32'(mdu_timeout_o), 0);
    tick();
    chk("wd_flag", 32'(mdu_timeout_o), 1);
    chk("wd_stall", 32'(stall_cnt_o), 15);
    #1 chk("wd_run", 32'(w_ctl), 32'(c_run));
    tick();
    tick();
    chk("wd_sticky", 32'(mdu_timeout_o), 1);

    // Reset while in MDU_WAIT
    idex_mdu_i = 1'b1;
    tick();
    idex_mdu_i = 1'b0;
    tick();
    do_reset();
    chk("rstw_tmo", 32'(mdu_timeout_o), 0);
    chk("rstw_stall", 32'(stall_cnt_o), 0);
    chk("rstw_flush", 32'(flush_cnt_o), 0);
    #1 chk("rstw_run", 32'(w_ctl), 32'(c_run));

    // Freeze beats a branch; branch honoured once busy drops
    branch_taken_i = 1'b1; dmem_busy_i = 1'b1;
    #1 chk("fz_br", 32'(w_ctl), 32'(c_freeze));
    tick();
    chk("fz_nocnt", 32'(flush_cnt_o), 0);
    dmem_busy_i = 1'b0;
    #1 chk("fz_br_go", 32'(w_ctl), 32'(c_flush));
    tick();
    branch_taken_i = 1'b0;
    chk("fz_brcnt", 32'(flush_cnt_o), 1);
    #1 chk("fz_redir", 32'(w_ctl), 32'(c_flush));
    tick();
    #1 chk("fz_brend", 32'(w_ctl), 32'(c_run));

    // Freeze swallows mdu_done; release happens via the remembered completion
    idex_mdu_i = 1'b1;
    tick();
    idex_mdu_i = 1'b0;
    dmem_busy_i = 1'b1; mdu_done_i = 1'b1;
    #1 chk("fz_mdu", 32'(w_ctl), 32'(c_freeze));
    tick();
    dmem_busy_i = 1'b0; mdu_done_i = 1'b0;
    #1 chk("fz_seen", 32'(w_ctl), 32'(c_run));
    tick();
    #1 chk("fz_after", 32'(w_ctl), 32'(c_run));
    chk("fz_stall", 32'(stall_cnt_o), 3);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
